// File: rtl/pipe_skid_stage_if.sv
// Handshake and payload bundle between the ID stage, the skid stage and EX.
// The slave modport is the stage itself; master is the surrounding environment.
interface pipe_skid_stage_if #(
  parameter int DATA_W  = 32,
  parameter int NUM_OPS = 3,
  parameter int CTRL_W  = 9,
  parameter int ADDR_W  = 5
);
  logic                        in_valid;
  logic                        in_ready;
  logic [CTRL_W-1:0]           in_ctrl;
  logic [NUM_OPS*DATA_W-1:0]   in_data;
  logic [3*ADDR_W-1:0]         in_addr;
  logic                        out_valid;
  logic                        out_ready;
  logic [CTRL_W-1:0]           out_ctrl;
  logic [NUM_OPS*DATA_W-1:0]   out_data;
  logic [3*ADDR_W-1:0]         out_addr;
  logic [1:0]                  occupancy;

  modport slave (
    input  in_valid, in_ctrl, in_data, in_addr, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, out_addr, occupancy
  );

  modport master (
    output in_valid, in_ctrl, in_data, in_addr, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, out_addr, occupancy
  );
endinterface

// File: rtl/pipe_skid_stage.sv
// ID/EX pipeline register with a one-entry skid buffer: fully registered
// handshake in both directions, strict FIFO order, flush kills both entries.
module pipe_skid_stage #(
  parameter int DATA_W  = 32,
  parameter int NUM_OPS = 3,
  parameter int CTRL_W  = 9,
  parameter int ADDR_W  = 5
) (
  input logic               clk,
  input logic               reset,
  input logic               flush,
  pipe_skid_stage_if.slave  bus
);
  localparam int DW = NUM_OPS * DATA_W;
  localparam int AW = 3 * ADDR_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [CTRL_W-1:0] main_ctrl_r, main_ctrl_s, skid_ctrl_r, skid_ctrl_s;
  logic [DW-1:0]     main_data_r, main_data_s, skid_data_r, skid_data_s;
  logic [AW-1:0]     main_addr_r, main_addr_s, skid_addr_r, skid_addr_s;
  logic              in_ready_r, out_valid_r;
  logic [1:0]        occupancy_r, occupancy_s;
  logic              in_xfer_s, out_xfer_s;

  assign in_xfer_s  = bus.in_valid & in_ready_r;
  assign out_xfer_s = out_valid_r & bus.out_ready;

  // Next-state and payload steering; main ctrl is zeroed whenever the stage empties.
  always_comb begin
    state_s     = state_r;
    main_ctrl_s = main_ctrl_r;
    main_data_s = main_data_r;
    main_addr_s = main_addr_r;
    skid_ctrl_s = skid_ctrl_r;
    skid_data_s = skid_data_r;
    skid_addr_s = skid_addr_r;
    if (flush) begin
      state_s     = ST_EMPTY;
      main_ctrl_s = {CTRL_W{1'b0}};
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_xfer_s) begin
            state_s     = ST_ONE;
            main_ctrl_s = bus.in_ctrl;
            main_data_s = bus.in_data;
            main_addr_s = bus.in_addr;
          end else begin
            state_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          case ({in_xfer_s, out_xfer_s})
            2'b10: begin
              state_s     = ST_TWO;
              skid_ctrl_s = bus.in_ctrl;
              skid_data_s = bus.in_data;
              skid_addr_s = bus.in_addr;
            end
            2'b01: begin
              state_s     = ST_EMPTY;
              main_ctrl_s = {CTRL_W{1'b0}};
            end
            2'b11: begin
              state_s     = ST_ONE;
              main_ctrl_s = bus.in_ctrl;
              main_data_s = bus.in_data;
              main_addr_s = bus.in_addr;
            end
            default: state_s = ST_ONE;
          endcase
        end
        ST_TWO: begin
          if (out_xfer_s) begin
            state_s     = ST_ONE;
            main_ctrl_s = skid_ctrl_r;
            main_data_s = skid_data_r;
            main_addr_s = skid_addr_r;
          end else begin
            state_s = ST_TWO;
          end
        end
        default: begin
          state_s     = ST_EMPTY;
          main_ctrl_s = {CTRL_W{1'b0}};
        end
      endcase
    end
  end

  // Occupancy encoding of the next state.
  always_comb begin
    occupancy_s = 2'd0;
    case (state_s)
      ST_EMPTY: occupancy_s = 2'd0;
      ST_ONE:   occupancy_s = 2'd1;
      ST_TWO:   occupancy_s = 2'd2;
      default:  occupancy_s = 2'd0;
    endcase
  end

  // State, payload and handshake flops; in_ready never depends on out_ready combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_EMPTY;
      main_ctrl_r <= {CTRL_W{1'b0}};
      main_data_r <= {DW{1'b0}};
      main_addr_r <= {AW{1'b0}};
      skid_ctrl_r <= {CTRL_W{1'b0}};
      skid_data_r <= {DW{1'b0}};
      skid_addr_r <= {AW{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      occupancy_r <= 2'd0;
    end else begin
      state_r     <= state_s;
      main_ctrl_r <= main_ctrl_s;
      main_data_r <= main_data_s;
      main_addr_r <= main_addr_s;
      skid_ctrl_r <= skid_ctrl_s;
      skid_data_r <= skid_data_s;
      skid_addr_r <= skid_addr_s;
      in_ready_r  <= (state_s != ST_TWO);
      out_valid_r <= (state_s != ST_EMPTY);
      occupancy_r <= occupancy_s;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_ctrl  = main_ctrl_r;
  assign bus.out_data  = main_data_r;
  assign bus.out_addr  = main_addr_r;
  assign bus.occupancy = occupancy_r;
endmodule
